// File: rtl/explosion_engine.sv
// rtl/explosion_engine.sv - queues bomb events, walks each blast cross over the tile map, keeps flames lit
// Optional BRICK_COUNT_EN adds the saturating bricks_destroyed counter output.
module explosion_engine #(
  parameter int MAP_COLS     = 40,
  parameter int MAP_ROWS     = 30,
  parameter int BLAST_RANGE  = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLAME_SLOTS  = 4,
  parameter int FLAME_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        explosion_write_enable,
  input  logic [9:0]  exploding_bomb_x,
  input  logic [9:0]  exploding_bomb_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  output logic [10:0] map_addr,
  input  logic [1:0]  map_rd_data,
  output logic        map_we,
  output logic [1:0]  map_wr_data,
  output logic        explosion_on,
  output logic        player_hit,
  output logic        busy,
  output logic        overflow
`ifdef BRICK_COUNT_EN
  ,
  output logic [15:0] bricks_destroyed
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (FLAME_SLOTS > 1) ? $clog2(FLAME_SLOTS) : 1;
  localparam int TW = $clog2(FLAME_CYCLES + 1);
  localparam logic [6:0]    COLS7   = 7'(MAP_COLS);
  localparam logic [6:0]    ROWS7   = 7'(MAP_ROWS);
  localparam logic [10:0]   COLS11  = 11'(MAP_COLS);
  localparam logic [2:0]    RANGE3  = 3'(BLAST_RANGE);
  localparam logic [TW-1:0] FLAME_T = TW'(FLAME_CYCLES);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_RD, S_CHK, S_NEXT} state_t;
  typedef enum logic [1:0] {ARM_UP, ARM_DN, ARM_LF, ARM_RT} arm_t;

  state_t        state_q, state_d;
  arm_t          arm_q, arm_d;
  logic [2:0]    k_q, k_d;
  logic [SW-1:0] cur_q, cur_d;

  logic [5:0]    fifo_col_q [FIFO_DEPTH];
  logic [5:0]    fifo_col_d [FIFO_DEPTH];
  logic [5:0]    fifo_row_q [FIFO_DEPTH];
  logic [5:0]    fifo_row_d [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          slot_valid_q [FLAME_SLOTS];
  logic          slot_valid_d [FLAME_SLOTS];
  logic [5:0]    slot_col_q   [FLAME_SLOTS];
  logic [5:0]    slot_col_d   [FLAME_SLOTS];
  logic [5:0]    slot_row_q   [FLAME_SLOTS];
  logic [5:0]    slot_row_d   [FLAME_SLOTS];
  logic [2:0]    slot_up_q    [FLAME_SLOTS];
  logic [2:0]    slot_up_d    [FLAME_SLOTS];
  logic [2:0]    slot_dn_q    [FLAME_SLOTS];
  logic [2:0]    slot_dn_d    [FLAME_SLOTS];
  logic [2:0]    slot_lf_q    [FLAME_SLOTS];
  logic [2:0]    slot_lf_d    [FLAME_SLOTS];
  logic [2:0]    slot_rt_q    [FLAME_SLOTS];
  logic [2:0]    slot_rt_d    [FLAME_SLOTS];
  logic [TW-1:0] slot_timer_q [FLAME_SLOTS];
  logic [TW-1:0] slot_timer_d [FLAME_SLOTS];

  logic overflow_q, overflow_d;
  logic expl_q, expl_d;
  logic hit_q, hit_d;

  logic [6:0]  base_c, base_r, step, tile_c, tile_r;
  logic        tile_oob;
  logic [10:0] tile_addr;
  logic [9:0]  ctr_x, ctr_y;
  logic        pop, push, free_found;
  logic [SW-1:0] free_idx;
  logic        unused_bits;

  function automatic logic in_cross(input logic [5:0] pc, input logic [5:0] pr,
                                    input logic [5:0] c, input logic [5:0] r,
                                    input logic [2:0] up, input logic [2:0] dn,
                                    input logic [2:0] lf, input logic [2:0] rt);
    logic row_hit, col_hit;
    row_hit = (pr == r) && (({1'b0, pc} + {4'b0, lf}) >= {1'b0, c})
              && ({1'b0, pc} <= ({1'b0, c} + {4'b0, rt}));
    col_hit = (pc == c) && (({1'b0, pr} + {4'b0, up}) >= {1'b0, r})
              && ({1'b0, pr} <= ({1'b0, r} + {4'b0, dn}));
    return row_hit || col_hit;
  endfunction

  // Bounds are checked on the unwrapped 7-bit coordinate so col/row -1 is never mistaken for a real tile.
  always_comb begin
    base_c   = {1'b0, slot_col_q[cur_q]};
    base_r   = {1'b0, slot_row_q[cur_q]};
    step     = {4'b0, k_q};
    tile_c   = base_c;
    tile_r   = base_r;
    tile_oob = (base_c >= COLS7) || (base_r >= ROWS7);
    case (arm_q)
      ARM_UP: begin
        tile_oob = tile_oob || (step > base_r);
        tile_r   = base_r - step;
      end
      ARM_DN: begin
        tile_r   = base_r + step;
        tile_oob = tile_oob || (tile_r >= ROWS7);
      end
      ARM_LF: begin
        tile_oob = tile_oob || (step > base_c);
        tile_c   = base_c - step;
      end
      default: begin
        tile_c   = base_c + step;
        tile_oob = tile_oob || (tile_c >= COLS7);
      end
    endcase
    tile_addr = 11'(tile_r) * COLS11 + 11'(tile_c);
  end

  assign map_addr    = ((state_q == S_RD && !tile_oob) || state_q == S_CHK) ? tile_addr : 11'd0;
  assign map_we      = (state_q == S_CHK) && (map_rd_data == 2'b10) && !reset;
  assign map_wr_data = 2'b00;
  assign busy        = (state_q != S_IDLE) || (cnt_q != '0);
  assign overflow    = overflow_q;
  assign explosion_on = expl_q;
  assign player_hit  = hit_q;
  assign ctr_x       = b_x + 10'd8;
  assign ctr_y       = b_y + 10'd8;
  assign unused_bits = ^{exploding_bomb_x[3:0], exploding_bomb_y[3:0], v_x[3:0], v_y[3:0],
                         ctr_x[3:0], ctr_y[3:0]};

  always_comb begin
    state_d      = state_q;
    arm_d        = arm_q;
    k_d          = k_q;
    cur_d        = cur_q;
    fifo_col_d   = fifo_col_q;
    fifo_row_d   = fifo_row_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    slot_valid_d = slot_valid_q;
    slot_col_d   = slot_col_q;
    slot_row_d   = slot_row_q;
    slot_up_d    = slot_up_q;
    slot_dn_d    = slot_dn_q;
    slot_lf_d    = slot_lf_q;
    slot_rt_d    = slot_rt_q;
    slot_timer_d = slot_timer_q;
    overflow_d   = overflow_q;
    expl_d       = 1'b0;
    hit_d        = 1'b0;
    free_found   = 1'b0;
    free_idx     = '0;

    for (int i = 0; i < FLAME_SLOTS; i++) begin
      if (slot_valid_q[i]) begin
        slot_timer_d[i] = slot_timer_q[i] - 1'b1;
        if (slot_timer_q[i] == TW'(1)) slot_valid_d[i] = 1'b0;
        if (in_cross(v_x[9:4], v_y[9:4], slot_col_q[i], slot_row_q[i],
                     slot_up_q[i], slot_dn_q[i], slot_lf_q[i], slot_rt_q[i]))
          expl_d = 1'b1;
        if (in_cross(ctr_x[9:4], ctr_y[9:4], slot_col_q[i], slot_row_q[i],
                     slot_up_q[i], slot_dn_q[i], slot_lf_q[i], slot_rt_q[i]))
          hit_d = 1'b1;
      end
    end

    for (int i = FLAME_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end

    pop  = (state_q == S_ALLOC);
    push = explosion_write_enable && ((cnt_q != DEPTH_C) || pop);
    if (explosion_write_enable && !push) overflow_d = 1'b1;
    if (push) begin
      fifo_col_d[wp_q] = exploding_bomb_x[9:4];
      fifo_row_d[wp_q] = exploding_bomb_y[9:4];
      wp_d = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0 && free_found) begin
          cur_d   = free_idx;
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        slot_col_d[cur_q]   = fifo_col_q[rp_q];
        slot_row_d[cur_q]   = fifo_row_q[rp_q];
        slot_up_d[cur_q]    = 3'd0;
        slot_dn_d[cur_q]    = 3'd0;
        slot_lf_d[cur_q]    = 3'd0;
        slot_rt_d[cur_q]    = 3'd0;
        slot_valid_d[cur_q] = 1'b0;
        arm_d   = ARM_UP;
        k_d     = 3'd1;
        state_d = S_RD;
      end
      S_RD: state_d = tile_oob ? S_NEXT : S_CHK;
      S_CHK: begin
        state_d = S_NEXT;
        if (map_rd_data == 2'b00 || map_rd_data == 2'b10) begin
          case (arm_q)
            ARM_UP:  slot_up_d[cur_q] = k_q;
            ARM_DN:  slot_dn_d[cur_q] = k_q;
            ARM_LF:  slot_lf_d[cur_q] = k_q;
            default: slot_rt_d[cur_q] = k_q;
          endcase
          if (map_rd_data == 2'b00 && k_q != RANGE3) begin
            k_d     = k_q + 3'd1;
            state_d = S_RD;
          end
        end
      end
      S_NEXT: begin
        if (arm_q == ARM_RT) begin
          slot_valid_d[cur_q] = 1'b1;
          slot_timer_d[cur_q] = FLAME_T;
          state_d = S_IDLE;
        end else begin
          arm_d   = arm_t'(arm_q + 2'd1);
          k_d     = 3'd1;
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      arm_q      <= ARM_UP;
      k_q        <= 3'd1;
      cur_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      expl_q     <= 1'b0;
      hit_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_col_q[i] <= 6'd0;
        fifo_row_q[i] <= 6'd0;
      end
      for (int i = 0; i < FLAME_SLOTS; i++) begin
        slot_valid_q[i] <= 1'b0;
        slot_col_q[i]   <= 6'd0;
        slot_row_q[i]   <= 6'd0;
        slot_up_q[i]    <= 3'd0;
        slot_dn_q[i]    <= 3'd0;
        slot_lf_q[i]    <= 3'd0;
        slot_rt_q[i]    <= 3'd0;
        slot_timer_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      k_q          <= k_d;
      cur_q        <= cur_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      expl_q       <= expl_d;
      hit_q        <= hit_d;
      fifo_col_q   <= fifo_col_d;
      fifo_row_q   <= fifo_row_d;
      slot_valid_q <= slot_valid_d;
      slot_col_q   <= slot_col_d;
      slot_row_q   <= slot_row_d;
      slot_up_q    <= slot_up_d;
      slot_dn_q    <= slot_dn_d;
      slot_lf_q    <= slot_lf_d;
      slot_rt_q    <= slot_rt_d;
      slot_timer_q <= slot_timer_d;
    end
  end

`ifdef BRICK_COUNT_EN
  logic [15:0] bricks_q, bricks_d;

  always_comb begin
    bricks_d = bricks_q;
    if (map_we && bricks_q != 16'hFFFF) bricks_d = bricks_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bricks_q <= 16'd0;
    else       bricks_q <= bricks_d;
  end

  assign bricks_destroyed = bricks_q;
`endif

endmodule

// File: tb/tb_explosion_engine.sv
// tb/tb_explosion_engine.sv - directed checks for explosion_engine against a behavioural tile RAM
module tb_explosion_engine;
  localparam int FLAME = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, we;
  logic [9:0]  ex, ey, v_x, v_y, b_x, b_y;
  logic [10:0] map_addr;
  logic [1:0]  map_rd_data, map_wr_data;
  logic        map_we, explosion_on, player_hit, busy, overflow;
`ifdef BRICK_COUNT_EN
  logic [15:0] bricks_destroyed;
`endif

  logic [1:0]  mem [0:2047];
  logic        cfg_we, cfg_clr;
  logic [10:0] cfg_addr;
  logic [1:0]  cfg_data;

  logic        mon_clr;
  logic        seen [0:2047];
  int          n_seen, we_cnt;
  logic [10:0] we_addr, rd_max;
  logic [1:0]  we_data;

  int n_tests = 0;
  int n_fail  = 0;

  int b1x [4] = '{160, 320, 480, 160};
  int b1y [4] = '{160, 160, 160, 320};
  int b2x [5] = '{80, 480, 80, 480, 320};
  int b2y [5] = '{80, 80, 400, 400, 320};

  explosion_engine #(.FLAME_CYCLES(FLAME)) dut (
    .clk(clk), .reset(reset),
    .explosion_write_enable(we), .exploding_bomb_x(ex), .exploding_bomb_y(ey),
    .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y),
    .map_addr(map_addr), .map_rd_data(map_rd_data), .map_we(map_we), .map_wr_data(map_wr_data),
    .explosion_on(explosion_on), .player_hit(player_hit), .busy(busy), .overflow(overflow)
`ifdef BRICK_COUNT_EN
    , .bricks_destroyed(bricks_destroyed)
`endif
  );

  always @(posedge clk) begin
    if (cfg_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 2'b00;
    end else begin
      if (cfg_we) mem[cfg_addr] <= cfg_data;
      if (map_we) mem[map_addr] <= map_wr_data;
    end
    map_rd_data <= mem[map_addr];
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 2048; i++) seen[i] <= 1'b0;
      n_seen <= 0; we_cnt <= 0; rd_max <= '0; we_addr <= '0; we_data <= '0;
    end else begin
      if (map_we) begin
        we_cnt <= we_cnt + 1; we_addr <= map_addr; we_data <= map_wr_data;
      end
      if (map_addr != 11'd0 && !seen[map_addr]) begin
        seen[map_addr] <= 1'b1; n_seen <= n_seen + 1;
      end
      if (map_addr > rd_max) rd_max <= map_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int addr, input logic [1:0] data);
    @(negedge clk); cfg_addr = 11'(addr); cfg_data = data; cfg_we = 1'b1;
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input int x, input int y);
    @(negedge clk); we = 1'b1; ex = 10'(x); ey = 10'(y);
    @(negedge clk); we = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int i = 0;
    do begin @(negedge clk); i++; end while (busy && i < max_cycles);
    check(tag, busy, 0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic exp);
    @(negedge clk); v_x = 10'(x); v_y = 10'(y);
    @(negedge clk); check(tag, explosion_on, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hits, first_hit;
    reset = 1'b1; we = 1'b0; ex = '0; ey = '0; v_x = '0; v_y = '0;
    b_x = 10'd600; b_y = 10'd400;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_clr = 1'b1; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    cfg_clr = 1'b0; mon_clr = 1'b0;
    check("rst_expl", explosion_on, 0);
    check("rst_hit", player_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_we", map_we, 0);
    check("rst_addr", map_addr, 0);
    reset = 1'b0;

    // empty map, full cross at tile (10,10)
    mon_reset();
    strobe(160, 160);
    wait_idle("a_idle", 100);
    probe("a_lf_end", 112, 168, 1);
    probe("a_lf_out", 96, 168, 0);
    probe("a_rt_end", 208, 160, 1);
    probe("a_rt_out", 224, 160, 0);
    probe("a_up_end", 160, 112, 1);
    probe("a_up_out", 160, 96, 0);
    probe("a_dn_end", 168, 208, 1);
    probe("a_dn_out", 160, 224, 0);
    probe("a_diag", 176, 176, 0);
    probe("a_centre", 160, 160, 1);
    check("a_hit_far", player_hit, 0);
    #1 check("a_no_write", we_cnt, 0);

    // wall right of centre, brick two tiles up
    do_reset();
    set_tile(411, 2'b01);
    set_tile(330, 2'b10);
    mon_reset();
    strobe(160, 160);
    wait_idle("b_idle", 100);
    #1;
    check("b_we_cnt", we_cnt, 1);
    check("b_we_addr", we_addr, 330);
    check("b_we_data", we_data, 0);
    check("b_brick_gone", mem[330], 0);
    check("b_wall_kept", mem[411], 1);
`ifdef BRICK_COUNT_EN
    check("b_brick_count", bricks_destroyed, 1);
`endif
    probe("b_rt_len0", 176, 160, 0);
    probe("b_up_brick", 160, 128, 1);
    probe("b_up_past", 160, 112, 0);
    probe("b_lf_len3", 112, 160, 1);
    probe("b_dn_len3", 160, 208, 1);

    // corner event: up/left arms clipped
    do_reset();
    set_tile(411, 2'b00);
    mon_reset();
    strobe(0, 0);
    wait_idle("c_idle", 100);
    #1;
    check("c_reads", n_seen, 6);
    check("c_rd_max", rd_max, 120);
    check("c_no_write", we_cnt, 0);
    probe("c_rt_end", 48, 0, 1);
    probe("c_rt_out", 64, 0, 0);
    probe("c_dn_end", 0, 48, 1);
    probe("c_dn_out", 0, 64, 0);

    // fill every slot, then over-fill the queue
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); we = 1'b1; ex = 10'(b1x[i]); ey = 10'(b1y[i]);
    end
    @(negedge clk); we = 1'b0;
    wait_idle("d_fill_idle", 300);
    check("d_ovf_before", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); we = 1'b1; ex = 10'(b2x[i]); ey = 10'(b2y[i]);
    end
    @(negedge clk); we = 1'b0;
    check("d_ovf_set", overflow, 1);
    check("d_busy_wait", busy, 1);
    wait_idle("d_drain_idle", 800);
    check("d_ovf_sticky", overflow, 1);
    probe("d_q0", 80, 80, 1);
    probe("d_q1", 480, 80, 1);
    probe("d_q2", 80, 400, 1);
    probe("d_q3", 480, 400, 1);
    probe("d_dropped", 320, 320, 0);

    // player on the right arm, flame lifetime and slot reuse
    do_reset();
    b_x = 10'd184; b_y = 10'd160;
    strobe(160, 160);
    wait_idle("e_idle", 100);
    hits = 0; first_hit = 0;
    for (int i = 0; i < FLAME + 20; i++) begin
      @(negedge clk);
      if (i == 0) first_hit = int'(player_hit);
      if (player_hit) hits++;
    end
    check("e_hit_first", first_hit, 1);
    check("e_hit_cycles", hits, FLAME);
    check("e_hit_expired", player_hit, 0);
    strobe(160, 160);
    wait_idle("e_reuse_idle", 100);
    @(negedge clk);
    check("e_reuse_hit", player_hit, 1);

    // reset while the brick write is pending
    do_reset();
    b_x = 10'd600; b_y = 10'd400;
    set_tile(330, 2'b10);
    strobe(160, 160);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!map_we && n < 60);
    end
    check("f_we_seen", map_we, 1);
    reset = 1'b1;
    #1 check("f_we_gated", map_we, 0);
    @(negedge clk);
    check("f_busy", busy, 0);
    check("f_expl", explosion_on, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("f_brick_kept", mem[330], 2);
    check("f_still_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
